sr_flag_arbiter: RTL and testbench

- Shares one bank of M SR-style flag bits among N requesters.
- Each requester issues set/clear commands against a flag index through a valid/ready handshake.
- A round-robin arbiter accepts one command per cycle and applies it to the bank. Illegal S=R=1 commands are detected and reported instead of driving any flag to an undefined value.
- Sits between control agents and the status flags they share, replacing ad-hoc per-agent SR flip-flops.

---
 rtl/sr_flag_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/sr_flag_arbiter.sv | 103 ++++++++++
 tb/tb_sr_flag_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_flag_pkg.sv
// Shared constants and helpers for the SR flag arbiter.
package sr_flag_pkg;

    // Command encoding on {s, r}
    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_CLR = 2'b01;
    localparam logic [1:0] CMD_SET = 2'b10;
    localparam logic [1:0] CMD_ILL = 2'b11;

    // Ceiling log2, minimum 1 so a width is never zero
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// searching cyclically. The pointer register lives in the parent.
module rr_arbiter
    import sr_flag_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int REQ_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [REQ_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [REQ_W-1:0] grant_id
);

    logic found;
    int   pos;

    // Cyclic priority search starting at the pointer
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        pos      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                grant_id   = REQ_W'(pos);
            end
        end
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Shared bank of SR flags written by N requesters through a round-robin
// valid/ready port. S=R=1 commands leave the bank untouched and are logged
// in sticky error registers instead.
module sr_flag_arbiter
    import sr_flag_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int N_FLAG = 8,
    parameter int IDX_W  = clog2(N_FLAG),
    parameter int REQ_W  = clog2(N_REQ),
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_s,
    input  logic [N_REQ-1:0]       req_r,
    input  logic [N_REQ*IDX_W-1:0] req_idx,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_FLAG-1:0]      flags,
    output logic                   err,
    output logic [REQ_W-1:0]       err_src,
    output logic [CNT_W-1:0]       err_cnt,
    input  logic                   clr_err
);

    logic [REQ_W-1:0]  ptr;
    logic [N_REQ-1:0]  grant;
    logic [REQ_W-1:0]  gid;
    logic              xfer;
    logic [1:0]        cmd;
    logic [IDX_W-1:0]  sel_idx;
    logic              illegal;
    logic [N_FLAG-1:0] flags_nxt;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .REQ_W (REQ_W)
    ) u_rr_arbiter (
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (gid)
    );

    // Grant gating and decode of the winning command
    always_comb begin
        req_ready = reset ? '0 : grant;
        xfer      = |req_ready;
        cmd       = {req_s[gid], req_r[gid]};
        sel_idx   = req_idx[int'(gid)*IDX_W +: IDX_W];
        illegal   = xfer && (cmd == CMD_ILL);
    end

    // Next flag bank; out-of-range indices fall through as no-ops
    always_comb begin
        flags_nxt = flags;
        if (xfer && (int'(sel_idx) < N_FLAG)) begin
            case (cmd)
                CMD_SET: flags_nxt[sel_idx] = 1'b1;
                CMD_CLR: flags_nxt[sel_idx] = 1'b0;
                default: flags_nxt = flags;
            endcase
        end
    end

    // Flag bank and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= '0;
            ptr   <= '0;
        end else begin
            flags <= flags_nxt;
            if (xfer) begin
                ptr <= (gid == REQ_W'(N_REQ - 1)) ? '0 : gid + 1'b1;
            end
        end
    end

    // Error logging; a new illegal command takes priority over clr_err
    always_ff @(posedge clk) begin
        if (reset) begin
            err     <= 1'b0;
            err_src <= '0;
            err_cnt <= '0;
        end else if (illegal) begin
            err <= 1'b1;
            if (!err || clr_err) begin
                err_src <= gid;
            end
            if (clr_err) begin
                err_cnt <= CNT_W'(1);
            end else if (err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end else if (clr_err) begin
            err     <= 1'b0;
            err_src <= '0;
            err_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed testbench for sr_flag_arbiter (N_REQ=4, N_FLAG=8).
module tb_sr_flag_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req_valid;
    logic [3:0] req_s;
    logic [3:0] req_r;
    logic [11:0] req_idx;
    logic [3:0] req_ready;
    logic [7:0] flags;
    logic       err;
    logic [1:0] err_src;
    logic [7:0] err_cnt;
    logic       clr_err;

    int total;
    int bad;

    sr_flag_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_s     (req_s),
        .req_r     (req_r),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .flags     (flags),
        .err       (err),
        .err_src   (err_src),
        .err_cnt   (err_cnt),
        .clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int k, input logic v, input logic s, input logic r, input int idx);
        req_valid[k] = v;
        req_s[k]     = s;
        req_r[k]     = r;
        req_idx[k*3 +: 3] = idx[2:0];
        #1;
    endtask

    task automatic idle_all();
        req_valid = '0;
        req_s     = '0;
        req_r     = '0;
        req_idx   = '0;
        clr_err   = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'b1111;
        step();
        step();
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_ready actual=%b required=%b", req_ready, 4'b0000);
        end
        total++;
        if (flags !== 8'h00) begin
            bad++; $display("FAIL reset_flags actual=%h required=%h", flags, 8'h00);
        end
        total++;
        if (err !== 1'b0 || err_cnt !== 8'h00 || err_src !== 2'd0) begin
            bad++; $display("FAIL reset_err actual=%b/%0d/%0d required=0/0/0", err, err_src, err_cnt);
        end
        reset = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL first_grant actual=%b required=%b", req_ready, 4'b0001);
        end
        step();   // NOP from requester 0 consumed, ptr -> 1
        total++;
        if (flags !== 8'h00) begin
            bad++; $display("FAIL nop_flags actual=%h required=%h", flags, 8'h00);
        end
        idle_all();
    endtask

    task automatic test_single_set_clear();
        set_cmd(2, 1'b1, 1'b1, 1'b0, 5);
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL set_ready actual=%b required=%b", req_ready, 4'b0100);
        end
        step();
        total++;
        if (flags !== 8'h20) begin
            bad++; $display("FAIL set_flags actual=%h required=%h", flags, 8'h20);
        end
        set_cmd(2, 1'b1, 1'b0, 1'b1, 5);
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL clr_ready actual=%b required=%b", req_ready, 4'b0100);
        end
        step();
        total++;
        if (flags !== 8'h00) begin
            bad++; $display("FAIL clr_flags actual=%h required=%h", flags, 8'h00);
        end
        idle_all();
    endtask

    task automatic test_contention();
        int g_exp[6] = '{0, 1, 3, 0, 1, 3};
        logic [7:0] f_exp[6] = '{8'h01, 8'h03, 8'h0B, 8'h0A, 8'h08, 8'h00};
        // ptr is 3 here; a lone NOP from requester 3 moves it to 0
        set_cmd(3, 1'b1, 1'b0, 1'b0, 0);
        step();
        set_cmd(0, 1'b1, 1'b1, 1'b0, 0);
        set_cmd(1, 1'b1, 1'b1, 1'b0, 1);
        set_cmd(3, 1'b1, 1'b1, 1'b0, 3);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (req_ready !== (4'b0001 << g_exp[i])) begin
                bad++; $display("FAIL cont_grant[%0d] actual=%b required=%b", i, req_ready, 4'b0001 << g_exp[i]);
            end
            step();
            total++;
            if (flags !== f_exp[i]) begin
                bad++; $display("FAIL cont_flags[%0d] actual=%h required=%h", i, flags, f_exp[i]);
            end
            // Granted requester switches to clearing its own flag
            set_cmd(g_exp[i], 1'b1, 1'b0, 1'b1, g_exp[i]);
        end
        idle_all();
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 8; i++) begin
            set_cmd(0, 1'b1, 1'b1, 1'b0, i);
            step();
        end
        idle_all();
        total++;
        if (flags !== 8'hFF) begin
            bad++; $display("FAIL fill_flags actual=%h required=%h", flags, 8'hFF);
        end
        set_cmd(1, 1'b1, 1'b1, 1'b1, 2);
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL ill_ready actual=%b required=%b", req_ready, 4'b0010);
        end
        step();
        idle_all();
        total++;
        if (flags !== 8'hFF) begin
            bad++; $display("FAIL ill_flags actual=%h required=%h", flags, 8'hFF);
        end
        total++;
        if (err !== 1'b1 || err_src !== 2'd1 || err_cnt !== 8'd1) begin
            bad++; $display("FAIL ill_first actual=%b/%0d/%0d required=1/1/1", err, err_src, err_cnt);
        end
        set_cmd(3, 1'b1, 1'b1, 1'b1, 6);
        step();
        idle_all();
        total++;
        if (err !== 1'b1 || err_src !== 2'd1 || err_cnt !== 8'd2) begin
            bad++; $display("FAIL ill_second actual=%b/%0d/%0d required=1/1/2", err, err_src, err_cnt);
        end
    endtask

    task automatic test_saturation_clear();
        set_cmd(2, 1'b1, 1'b1, 1'b1, 4);
        for (int i = 0; i < 300; i++) begin
            step();
        end
        idle_all();
        total++;
        if (err_cnt !== 8'hFF || err_src !== 2'd1) begin
            bad++; $display("FAIL sat_cnt actual=%0d/%h required=1/ff", err_src, err_cnt);
        end
        total++;
        if (flags !== 8'hFF) begin
            bad++; $display("FAIL sat_flags actual=%h required=%h", flags, 8'hFF);
        end
        set_cmd(0, 1'b1, 1'b1, 1'b1, 0);
        clr_err = 1'b1;
        step();
        idle_all();
        total++;
        if (err !== 1'b1 || err_src !== 2'd0 || err_cnt !== 8'd1) begin
            bad++; $display("FAIL clr_with_ill actual=%b/%0d/%0d required=1/0/1", err, err_src, err_cnt);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        total++;
        if (err !== 1'b0 || err_src !== 2'd0 || err_cnt !== 8'd0) begin
            bad++; $display("FAIL clr_alone actual=%b/%0d/%0d required=0/0/0", err, err_src, err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int clr_list[4] = '{0, 2, 5, 7};
        for (int i = 0; i < 4; i++) begin
            set_cmd(0, 1'b1, 1'b0, 1'b1, clr_list[i]);
            step();
        end
        idle_all();
        total++;
        if (flags !== 8'h5A) begin
            bad++; $display("FAIL mid_pre_flags actual=%h required=%h", flags, 8'h5A);
        end
        set_cmd(0, 1'b1, 1'b1, 1'b0, 0);
        reset = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL mid_ready_in_reset actual=%b required=%b", req_ready, 4'b0000);
        end
        step();
        total++;
        if (flags !== 8'h00) begin
            bad++; $display("FAIL mid_flags_reset actual=%h required=%h", flags, 8'h00);
        end
        reset = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL mid_ready_after actual=%b required=%b", req_ready, 4'b0001);
        end
        step();
        idle_all();
        total++;
        if (flags !== 8'h01) begin
            bad++; $display("FAIL mid_flags_after actual=%h required=%h", flags, 8'h01);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        req_valid = '0;
        req_s     = '0;
        req_r     = '0;
        req_idx   = '0;
        clr_err   = 1'b0;
        test_reset();
        test_single_set_clear();
        test_contention();
        test_illegal();
        test_saturation_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
